// File: rtl/free_list_pkg.sv
// Shared rename-stage types: physical tag layout and free-list sizing.
// The free list recycles tags 32..63 at reset; 0..31 start out mapped.
package free_list_pkg;

  localparam int PHYS_REG_SZ = 64;
  localparam int ARCH_REG_SZ = 32;
  localparam int FL_DEPTH    = PHYS_REG_SZ - ARCH_REG_SZ;
  localparam int PR_W        = $clog2(PHYS_REG_SZ);

  typedef struct packed {
    logic [PR_W-1:0] phys_reg;
    logic            ready;
  } tag_t;

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical tags: retire pushes, dispatch pops.
// Pointers wrap by compare against DEPTH-1, so DEPTH need not be 2^n.
module free_list
  import free_list_pkg::*;
#(
  parameter int PHYS_REG_SZ = free_list_pkg::PHYS_REG_SZ,
  parameter int ARCH_REG_SZ = free_list_pkg::ARCH_REG_SZ
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  tag_t                                  push_t,
  input  logic                                  push_en,
  input  logic                                  pop_en,
  output tag_t                                  free_t,
  output logic                                  avail,
  output logic [$clog2(PHYS_REG_SZ-ARCH_REG_SZ+1)-1:0] free_count,
  output logic                                  overflow
);

  localparam int DEPTH = PHYS_REG_SZ - ARCH_REG_SZ;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PR_W-1:0]  entry [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic pop_ok;
  logic push_ok;
  logic full;
  logic unused_ready;

  function automatic logic [PTR_W-1:0] next_ptr(
    input logic [PTR_W-1:0] p
  );
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign unused_ready = push_t.ready;

  assign full    = (count == CNT_W'(DEPTH));
  assign avail   = (count != '0);
  assign pop_ok  = pop_en && avail;
  // A pop in the same cycle frees a slot, so full + pop still accepts.
  assign push_ok = push_en && (!full || pop_ok);

  assign free_t.phys_reg = entry[head];
  assign free_t.ready    = 1'b0;
  assign free_count      = count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= PR_W'(ARCH_REG_SZ + i);
      end
    end else if (push_ok) begin
      entry[tail] <= push_t.phys_reg;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= CNT_W'(DEPTH);
      overflow <= 1'b0;
    end else begin
      if (pop_ok) begin
        head <= next_ptr(head);
      end
      if (push_ok) begin
        tail <= next_ptr(tail);
      end
      unique case (1'b1)
        push_ok && !pop_ok: count <= count + 1'b1;
        pop_ok && !push_ok: count <= count - 1'b1;
        default:            count <= count;
      endcase
      if (push_en && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: a tag-queue model predicts each cycle.
// Expected snapshots are queued at drive time and compared after the edge.
module tb_free_list;
  import free_list_pkg::*;

  typedef struct {
    int avail;
    int cnt;
    int head;
    int ovf;
  } exp_t;

  logic       clock;
  logic       reset;
  tag_t       push_t;
  logic       push_en;
  logic       pop_en;
  tag_t       free_t;
  logic       avail;
  logic [5:0] free_count;
  logic       overflow;

  int   checks;
  int   errors;
  int   fl[$];
  bit   ovf;
  exp_t sb[$];

  free_list dut (
    .clock      (clock),
    .reset      (reset),
    .push_t     (push_t),
    .push_en    (push_en),
    .pop_en     (pop_en),
    .free_t     (free_t),
    .avail      (avail),
    .free_count (free_count),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fl.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
    ovf = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_avail"}, int'(avail), (fl.size() != 0) ? 1 : 0);
    check({tag, "_count"}, int'(free_count), fl.size());
    check({tag, "_ovf"}, int'(overflow), int'(ovf));
    if (fl.size() != 0) begin
      check({tag, "_head"}, int'(free_t.phys_reg), fl[0]);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    push_en = 1'b0;
    pop_en  = 1'b0;
    push_t  = '0;
    #3;
    model_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic step(input bit ps, input int tag, input bit pp);
    bit   pop_ok;
    bit   push_ok;
    exp_t e;
    push_en         = ps;
    pop_en          = pp;
    push_t.phys_reg = PR_W'(tag);
    push_t.ready    = 1'b1;
    pop_ok  = pp && (fl.size() != 0);
    push_ok = ps && (fl.size() < 32 || pop_ok);
    #1;
    if (pop_ok) begin
      check("pop_tag", int'(free_t.phys_reg), fl[0]);
      void'(fl.pop_front());
    end
    if (push_ok) fl.push_back(tag);
    if (ps && !push_ok) ovf = 1'b1;
    e.avail = (fl.size() != 0) ? 1 : 0;
    e.cnt   = fl.size();
    e.head  = (fl.size() != 0) ? fl[0] : -1;
    e.ovf   = int'(ovf);
    sb.push_back(e);
    @(posedge clock);
    #1;
    push_en = 1'b0;
    pop_en  = 1'b0;
    e = sb.pop_front();
    check("avail", int'(avail), e.avail);
    check("count", int'(free_count), e.cnt);
    check("ovf", int'(overflow), e.ovf);
    if (e.head >= 0) check("head", int'(free_t.phys_reg), e.head);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    push_en = 1'b0;
    pop_en  = 1'b0;
    push_t  = '0;
    #2;

    do_reset();
    check("rst_avail", int'(avail), 1);
    check("rst_count", int'(free_count), 32);
    check("rst_head", int'(free_t.phys_reg), 32);
    check("rst_ovf", int'(overflow), 0);

    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1);
    check("pop3_count", int'(free_count), 29);

    do_reset();
    for (int i = 0; i < 32; i++) step(1'b0, 0, 1'b1);
    check("drain_avail", int'(avail), 0);
    check("drain_count", int'(free_count), 0);
    step(1'b0, 0, 1'b1);
    step(1'b1, 5, 1'b0);
    check("refill_head", int'(free_t.phys_reg), 5);
    step(1'b0, 0, 1'b1);
    step(1'b1, 9, 1'b1);
    check("empty_pp_count", int'(free_count), 1);
    check("empty_pp_head", int'(free_t.phys_reg), 9);

    do_reset();
    step(1'b1, 7, 1'b1);
    check("full_pp_ovf", int'(overflow), 0);
    for (int i = 0; i < 31; i++) step(1'b0, 0, 1'b1);
    check("slot0_tag", int'(free_t.phys_reg), 7);

    do_reset();
    step(1'b1, 3, 1'b0);
    check("ovf_set", int'(overflow), 1);
    check("ovf_count", int'(free_count), 32);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1);
    step(1'b1, 11, 1'b0);
    check("ovf_sticky", int'(overflow), 1);

    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, i, 1'b1);
    check("wrap_head", int'(free_t.phys_reg), 8);
    for (int i = 0; i < 32; i++) step(1'b0, 0, 1'b1);
    check("wrap_empty", int'(avail), 0);

    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1);
    push_en = 1'b1;
    pop_en  = 1'b1;
    push_t  = '0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_idle("async");
    push_en = 1'b0;
    pop_en  = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_idle("async_rel");
    step(1'b0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
